// File: rtl/dice_roll_arbiter.sv
// Round-robin arbiter that lends the shared dice-sum counter to one of two players and scores each roll with craps rules.
// Optional WIN_CNT_EN adds saturating per-player win counters (wins0/wins1).
module dice_roll_arbiter #(
  parameter int MIN_ROLL_CYC = 4,
  parameter int MAX_ROLL_CYC = 255,
  parameter int WCNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        roll_btn,
  input  logic [3:0]        dice_sum,
  output logic              cnt_en,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              res_valid,
  output logic              res_player,
  output logic [1:0]        res_code,
  output logic [3:0]        point0,
  output logic [3:0]        point1,
  output logic              err
`ifdef WIN_CNT_EN
  ,
  output logic [WCNT_W-1:0] wins0,
  output logic [WCNT_W-1:0] wins1
`endif
);

  localparam int RCW = $clog2(MAX_ROLL_CYC + 1);
  localparam logic [RCW-1:0] MIN_C = RCW'(MIN_ROLL_CYC);
  localparam logic [RCW-1:0] MAX_C = RCW'(MAX_ROLL_CYC);

  localparam logic [1:0] C_POINT = 2'b00;
  localparam logic [1:0] C_WIN   = 2'b01;
  localparam logic [1:0] C_LOSE  = 2'b10;
  localparam logic [1:0] C_NODEC = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_ROLL, S_SETTLE, S_EVAL, S_RELEASE} state_t;

  state_t         state_q, state_d;
  logic [1:0]     grant_q, grant_d;
  logic           last_q, last_d;
  logic [RCW-1:0] roll_cnt_q, roll_cnt_d;
  logic [3:0]     point0_q, point0_d, point1_q, point1_d;
  logic [1:0]     res_code_q, res_code_d;
  logic           res_player_q, res_player_d;
  logic           err_q, err_d;

  logic           gidx, btn_g, legal, winner;
  logic [3:0]     cur_pt, new_pt;
  logic [1:0]     code;

  // Craps scoring of the current sum against the granted player's point.
  always_comb begin
    gidx   = grant_q[1];
    btn_g  = roll_btn[gidx];
    cur_pt = gidx ? point1_q : point0_q;
    legal  = (dice_sum >= 4'd2) && (dice_sum <= 4'd12);
    new_pt = cur_pt;
    code   = C_NODEC;
    if (cur_pt == 4'd0) begin
      if (dice_sum == 4'd7 || dice_sum == 4'd11) begin
        code = C_WIN;
      end else if (dice_sum == 4'd2 || dice_sum == 4'd3 || dice_sum == 4'd12) begin
        code = C_LOSE;
      end else begin
        code   = C_POINT;
        new_pt = dice_sum;
      end
    end else if (dice_sum == cur_pt) begin
      code   = C_WIN;
      new_pt = 4'd0;
    end else if (dice_sum == 4'd7) begin
      code   = C_LOSE;
      new_pt = 4'd0;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    roll_cnt_d   = roll_cnt_q;
    point0_d     = point0_q;
    point1_d     = point1_q;
    res_code_d   = res_code_q;
    res_player_d = res_player_q;
    err_d        = err_q;
    cnt_en       = 1'b0;
    res_valid    = 1'b0;
    winner       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (roll_btn != 2'b00) begin
          winner     = (roll_btn == 2'b11) ? ~last_q : roll_btn[1];
          grant_d    = winner ? 2'b10 : 2'b01;
          last_d     = winner;
          roll_cnt_d = RCW'(1);
          state_d    = S_ROLL;
        end
      end
      S_ROLL: begin
        cnt_en = 1'b1;
        if ((!btn_g && roll_cnt_q >= MIN_C) || roll_cnt_q == MAX_C) begin
          state_d = S_SETTLE;
        end else begin
          roll_cnt_d = roll_cnt_q + RCW'(1);
        end
      end
      S_SETTLE: state_d = S_EVAL;
      S_EVAL: begin
        state_d = S_RELEASE;
        if (legal) begin
          res_valid    = 1'b1;
          res_code_d   = code;
          res_player_d = gidx;
          if (gidx) point1_d = new_pt;
          else      point0_d = new_pt;
        end else begin
          err_d = 1'b1;
        end
      end
      S_RELEASE: begin
        if (!btn_g) begin
          grant_d = 2'b00;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      grant_q      <= 2'b00;
      last_q       <= 1'b1;
      roll_cnt_q   <= '0;
      point0_q     <= 4'd0;
      point1_q     <= 4'd0;
      res_code_q   <= 2'b00;
      res_player_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      roll_cnt_q   <= roll_cnt_d;
      point0_q     <= point0_d;
      point1_q     <= point1_d;
      res_code_q   <= res_code_d;
      res_player_q <= res_player_d;
      err_q        <= err_d;
    end
  end

  // Result fields are live during the EVAL pulse and held afterwards.
  assign res_code   = res_code_d;
  assign res_player = res_player_d;
  assign grant      = grant_q;
  assign busy       = (state_q != S_IDLE);
  assign point0     = point0_q;
  assign point1     = point1_q;
  assign err        = err_q;

`ifdef WIN_CNT_EN
  logic [WCNT_W-1:0] wins0_q, wins0_d, wins1_q, wins1_d;

  always_comb begin
    wins0_d = wins0_q;
    wins1_d = wins1_q;
    if (res_valid && res_code_d == C_WIN) begin
      if (!res_player_d && wins0_q != '1) wins0_d = wins0_q + WCNT_W'(1);
      if ( res_player_d && wins1_q != '1) wins1_d = wins1_q + WCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wins0_q <= '0;
      wins1_q <= '0;
    end else begin
      wins0_q <= wins0_d;
      wins1_q <= wins1_d;
    end
  end

  assign wins0 = wins0_q;
  assign wins1 = wins1_q;
`endif

endmodule

// File: tb/tb_dice_roll_arbiter.sv
// Randomized and directed bench for dice_roll_arbiter against a rule-level craps/arbitration model.
module tb_dice_roll_arbiter;

  localparam int MIN_C = 4;
  localparam int MAX_C = 255;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] roll_btn;
  logic [3:0] dice_sum;
  logic       cnt_en, busy, res_valid, res_player, err;
  logic [1:0] grant, res_code;
  logic [3:0] point0, point1;
`ifdef WIN_CNT_EN
  logic [7:0] wins0, wins1;
`endif

  dice_roll_arbiter #(.MIN_ROLL_CYC(MIN_C), .MAX_ROLL_CYC(MAX_C), .WCNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .roll_btn(roll_btn), .dice_sum(dice_sum),
    .cnt_en(cnt_en), .grant(grant), .busy(busy), .res_valid(res_valid),
    .res_player(res_player), .res_code(res_code), .point0(point0), .point1(point1),
    .err(err)
`ifdef WIN_CNT_EN
    , .wins0(wins0), .wins1(wins1)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observations of one roll
  int         o_en, o_nvalid, o_first_en, o_valid_k, o_idle_k;
  logic [1:0] o_code, o_gnt;
  logic       o_ply;
  bit         o_timeout;

  // Reference model state
  logic [3:0] m_pt [2];
  logic       m_last;
  logic [1:0] m_code;
  logic       m_ply;
  logic       m_err;
  // Expectations for the most recent roll
  logic [1:0] e_gnt, e_code;
  logic       e_valid, e_ply;
  int         e_en;

  task automatic do_reset();
    reset_n = 1'b0; roll_btn = 2'b00; dice_sum = 4'd2;
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    m_pt[0] = 0; m_pt[1] = 0; m_last = 1'b1; m_code = 2'b00; m_ply = 1'b0; m_err = 1'b0;
  endtask

  // Drive one roll (buttons high for `hold` sampling edges) and record what the DUT did.
  task automatic run_roll(input logic [1:0] btn, input int hold, input logic [3:0] sum);
    int k;
    bit seen_busy;
    o_en = 0; o_nvalid = 0; o_first_en = -1; o_valid_k = -1; o_idle_k = -1;
    o_code = 2'b00; o_gnt = 2'b00; o_ply = 1'b0; o_timeout = 1'b1; seen_busy = 1'b0;
    @(negedge clk); roll_btn = btn; dice_sum = sum;
    for (k = 1; k < 2000; k++) begin
      @(negedge clk);
      if (k >= hold) roll_btn = 2'b00;
      if (cnt_en) begin o_en++; if (o_first_en < 0) o_first_en = k; end
      if (busy) begin seen_busy = 1'b1; if (grant != 2'b00) o_gnt = grant; end
      if (res_valid) begin
        o_nvalid++; o_code = res_code; o_ply = res_player;
        if (o_valid_k < 0) o_valid_k = k;
      end
      if (seen_busy && !busy) begin o_timeout = 1'b0; o_idle_k = k; break; end
    end
    if (o_timeout) begin
      errors++;
      $display("FAIL roll_timeout: busy never returned low, required idle within 2000 cycles");
    end
  endtask

  // Rule-level expectation for a roll; advances the model.
  task automatic model_roll(input logic [1:0] btn, input int hold, input logic [3:0] sum);
    logic p;
    p = (btn == 2'b11) ? ~m_last : btn[1];
    m_last = p;
    e_gnt = p ? 2'b10 : 2'b01;
    e_en = (hold < MIN_C) ? MIN_C : (hold > MAX_C) ? MAX_C : hold;
    e_valid = 1'b1;
    if (sum < 2 || sum > 12) begin
      e_valid = 1'b0; m_err = 1'b1;
    end else if (m_pt[p] == 0) begin
      if (sum == 7 || sum == 11) m_code = 2'b01;
      else if (sum == 2 || sum == 3 || sum == 12) m_code = 2'b10;
      else begin m_code = 2'b00; m_pt[p] = sum; end
    end else if (sum == m_pt[p]) begin
      m_code = 2'b01; m_pt[p] = 0;
    end else if (sum == 7) begin
      m_code = 2'b10; m_pt[p] = 0;
    end else m_code = 2'b11;
    if (e_valid) m_ply = p;
    e_code = m_code; e_ply = m_ply;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk); roll_btn = 2'b10; dice_sum = 4'd5;
    repeat (3) @(negedge clk);
    checks++;
    if (cnt_en !== 1'b1) begin errors++; $display("FAIL reset_pre_roll: cnt_en=%0b required 1", cnt_en); end
    reset_n = 1'b0; roll_btn = 2'b00;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    checks++;
    if ({cnt_en, grant, busy, res_valid, res_player, res_code, point0, point1, err} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs: cnt_en=%0b grant=%b busy=%0b rv=%0b rp=%0b rc=%b p0=%0d p1=%0d err=%0b required all 0",
               cnt_en, grant, busy, res_valid, res_player, res_code, point0, point1, err);
    end
    m_pt[0] = 0; m_pt[1] = 0; m_last = 1'b1; m_code = 2'b00; m_ply = 1'b0; m_err = 1'b0;
    model_roll(2'b11, 2, 4'd7);
    run_roll(2'b11, 2, 4'd7);
    checks++;
    if (o_gnt !== 2'b01) begin errors++; $display("FAIL reset_tie_grant: grant=%b required 01", o_gnt); end
  endtask

  task automatic test_basic_win();
    do_reset();
    model_roll(2'b01, 6, 4'd7);
    run_roll(2'b01, 6, 4'd7);
    checks++;
    if (o_en !== 6) begin errors++; $display("FAIL win_en_cycles: %0d required 6", o_en); end
    checks++;
    if (o_nvalid !== 1 || o_ply !== 1'b0 || o_code !== 2'b01) begin
      errors++; $display("FAIL win_result: nvalid=%0d player=%0b code=%b required 1/0/01", o_nvalid, o_ply, o_code);
    end
    checks++;
    if (point0 !== 4'd0) begin errors++; $display("FAIL win_point0: %0d required 0", point0); end
    checks++;
    if (o_first_en !== 1 || o_valid_k !== 8) begin
      errors++; $display("FAIL latency: first_en=%0d valid_at=%0d required 1/8", o_first_en, o_valid_k);
    end
  endtask

  task automatic test_point_sequence();
    logic [3:0] sums [5];
    logic [1:0] codes [5];
    logic [3:0] pts [5];
    sums  = '{4'd5, 4'd9, 4'd5, 4'd4, 4'd7};
    codes = '{2'b00, 2'b11, 2'b01, 2'b00, 2'b10};
    pts   = '{4'd5, 4'd5, 4'd0, 4'd4, 4'd0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_roll(2'b01, 3, sums[i]);
      checks++;
      if (o_nvalid !== 1 || o_code !== codes[i] || point0 !== pts[i]) begin
        errors++;
        $display("FAIL point_seq[%0d]: nvalid=%0d code=%b point0=%0d required 1/%b/%0d",
                 i, o_nvalid, o_code, point0, codes[i], pts[i]);
      end
    end
  endtask

  task automatic test_tie_rr();
    logic [1:0] btns [4];
    logic [3:0] sums [4];
    btns = '{2'b11, 2'b11, 2'b01, 2'b10};
    sums = '{4'd8, 4'd6, 4'd7, 4'd6};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      model_roll(btns[i], 2, sums[i]);
      run_roll(btns[i], 2, sums[i]);
      checks++;
      if (o_gnt !== e_gnt || o_code !== e_code || o_ply !== e_ply || point0 !== m_pt[0] || point1 !== m_pt[1]) begin
        errors++;
        $display("FAIL tie_rr[%0d]: grant=%b code=%b ply=%0b p0=%0d p1=%0d required %b/%b/%0b/%0d/%0d",
                 i, o_gnt, o_code, o_ply, point0, point1, e_gnt, e_code, e_ply, m_pt[0], m_pt[1]);
      end
      if (i == 2) begin
        checks++;
        if (point1 !== 4'd6) begin errors++; $display("FAIL tie_point1_kept: %0d required 6", point1); end
      end
    end
  endtask

  task automatic test_min_max();
    do_reset();
    run_roll(2'b10, 1, 4'd8);
    checks++;
    if (o_en !== MIN_C) begin errors++; $display("FAIL min_roll: en=%0d required %0d", o_en, MIN_C); end
    run_roll(2'b01, 300, 4'd8);
    checks++;
    if (o_en !== MAX_C) begin errors++; $display("FAIL max_roll: en=%0d required %0d", o_en, MAX_C); end
    checks++;
    if (o_idle_k !== 301 || o_nvalid !== 1) begin
      errors++; $display("FAIL release_hold: idle_at=%0d nvalid=%0d required 301/1", o_idle_k, o_nvalid);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    run_roll(2'b01, 2, 4'd5);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_clear: err=%0b required 0", err); end
    run_roll(2'b01, 2, 4'd13);
    checks++;
    if (o_nvalid !== 0 || err !== 1'b1) begin
      errors++; $display("FAIL illegal_sum: nvalid=%0d err=%0b required 0/1", o_nvalid, err);
    end
    checks++;
    if (point0 !== 4'd5 || point1 !== 4'd0 || res_code !== 2'b00) begin
      errors++; $display("FAIL illegal_hold: p0=%0d p1=%0d code=%b required 5/0/00", point0, point1, res_code);
    end
  endtask

  task automatic test_random();
    logic [1:0] btn;
    logic [3:0] sum;
    int hold;
    logic [3:0] bad [5];
    bad = '{4'd0, 4'd1, 4'd13, 4'd14, 4'd15};
    do_reset();
    for (int i = 0; i < 40; i++) begin
      btn  = 2'($urandom_range(1, 3));
      hold = $urandom_range(1, 12);
      sum  = ($urandom_range(0, 15) == 0) ? bad[$urandom_range(0, 4)] : 4'($urandom_range(2, 12));
      model_roll(btn, hold, sum);
      run_roll(btn, hold, sum);
      checks++;
      if (o_gnt !== e_gnt || o_en !== e_en || o_nvalid !== (e_valid ? 1 : 0)) begin
        errors++;
        $display("FAIL rand_roll[%0d]: grant=%b en=%0d nvalid=%0d required %b/%0d/%0d",
                 i, o_gnt, o_en, o_nvalid, e_gnt, e_en, e_valid ? 1 : 0);
      end
      checks++;
      if (res_code !== e_code || res_player !== e_ply || point0 !== m_pt[0] || point1 !== m_pt[1] || err !== m_err) begin
        errors++;
        $display("FAIL rand_result[%0d]: code=%b ply=%0b p0=%0d p1=%0d err=%0b required %b/%0b/%0d/%0d/%0b",
                 i, res_code, res_player, point0, point1, err, e_code, e_ply, m_pt[0], m_pt[1], m_err);
      end
    end
  endtask

`ifdef WIN_CNT_EN
  task automatic test_wins();
    do_reset();
    for (int i = 0; i < 3; i++) run_roll(2'b10, 1, 4'd7);
    checks++;
    if (wins1 !== 8'd3 || wins0 !== 8'd0) begin
      errors++; $display("FAIL wins_count: wins1=%0d wins0=%0d required 3/0", wins1, wins0);
    end
    for (int i = 0; i < 253; i++) run_roll(2'b10, 1, 4'd11);
    checks++;
    if (wins1 !== 8'd255) begin errors++; $display("FAIL wins_saturate: wins1=%0d required 255", wins1); end
  endtask
`endif

  initial begin
    reset_n = 1'b0; roll_btn = 2'b00; dice_sum = 4'd2;
    test_reset();
    test_basic_win();
    test_point_sequence();
    test_tie_rr();
    test_min_max();
    test_illegal();
    test_random();
`ifdef WIN_CNT_EN
    test_wins();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dice_roll_arbiter.md
Name: dice_roll_arbiter

Overview:
- Shares the single 2..12 dice-sum counter between two players.
- Grants the counter to one player at a time, round-robin, and drives the counter's enable while that player holds the roll button.
- After the roll, samples the settled sum and evaluates it against craps rules using a separate point register per player.
- Sits between the player push-buttons and the sum counter; its results feed the display/LED logic.

Parameters:
MIN_ROLL_CYC, 4, minimum cycles cnt_en stays high per roll, even for a shorter press
MAX_ROLL_CYC, 255, maximum cycles cnt_en stays high per roll (timeout); must be >= MIN_ROLL_CYC
WCNT_W, 8, width of per-player win counters (used only with optional feature)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  synchronous, active-low reset
roll_btn  in  2  roll request per player (bit0 = player 0, bit1 = player 1), synchronous level
dice_sum  in  4  current sum from the dice counter; legal range 2..12
cnt_en  out  1  enable to the dice counter
grant  out  2  one-hot owner of the counter; 00 when idle
busy  out  1  high in every state except IDLE
res_valid  out  1  one-cycle pulse when a result is presented
res_player  out  1  player the result belongs to
res_code  out  2  00 POINT_SET, 01 WIN, 10 LOSE, 11 NO_DECISION
point0  out  4  player 0 point; 0 = no point established
point1  out  4  player 1 point; 0 = no point established
err  out  1  sticky illegal-sum flag; cleared only by reset

Behaviour:
- Reset (reset_n low at a clk edge) returns the block to IDLE regardless of current state, including mid-roll:
  - state = IDLE; cnt_en, grant, busy, res_valid, res_player, res_code, err all 0; point0 = point1 = 0; roll cycle counter = 0.
  - last_grant = player 1, so player 0 wins the first tie.
- States: IDLE -> ROLL -> SETTLE -> EVAL -> RELEASE -> IDLE.
- IDLE:
  - Exactly one roll_btn bit high: grant that player, go to ROLL next edge.
  - Both bits high: grant the player that is not last_grant, then update last_grant.
  - grant is registered and stays stable from ROLL through RELEASE.
- ROLL:
  - cnt_en = 1; roll counter increments each cycle, starting from 1 on the first ROLL cycle.
  - Exit to SETTLE on the edge where either condition holds:
    - the granted player's button is low and the roll counter >= MIN_ROLL_CYC, or
    - the roll counter == MAX_ROLL_CYC.
  - The other player's button is ignored.
- SETTLE: cnt_en = 0 for one cycle so the counter output is stable.
- EVAL: dice_sum is sampled; res_valid = 1 for this cycle only; res_player = granted player.
- Evaluation when the player's point = 0 (first roll):
  - 7 or 11: WIN.
  - 2, 3 or 12: LOSE.
  - Any other sum: POINT_SET, and the point is set to that sum.
- Evaluation when the player's point != 0:
  - sum == point: WIN, point cleared to 0.
  - sum == 7: LOSE, point cleared to 0.
  - Otherwise: NO_DECISION, point unchanged.
- Illegal sum (0, 1, 13..15) in EVAL:
  - res_valid stays 0; err set to 1; point unchanged; FSM still proceeds to RELEASE.
- res_code and res_player hold their last values until the next res_valid.
- RELEASE: wait until the granted player's button is low, then go to IDLE with grant = 00. This prevents a held button from immediately re-rolling.
- Latency:
  - Single-request press in IDLE: first cnt_en cycle comes 1 clk after the request is sampled.
  - Button release sampled in ROLL (once the min-cycle condition is met): res_valid comes 2 clks later.
- Points are kept per player, so interleaved turns preserve each player's point.

Optional Feature:
Macro WIN_CNT_EN.
- Defined:
  - Adds outputs wins0 and wins1 (WCNT_W bits each), reset to 0.
  - The counter of res_player increments on each res_valid with res_code = WIN.
  - Saturates at all-ones; no wrap.
- Not defined: no such ports or registers exist; all other behaviour is identical.

Test Plan:
- Hold reset_n low 2 cycles in mid-ROLL, then release -> all outputs 0, grant = 00, and the next request is granted to player 0.
- Player 0 presses for 6 cycles, bench drives dice_sum = 7 -> cnt_en high for 6 cycles, res_valid pulse, res_player = 0, res_code = 01, point0 = 0.
- Player 0 roll with sum 5 -> POINT_SET, point0 = 5. Next player 0 roll with sum 9 -> NO_DECISION. Next with sum 5 -> WIN, point0 = 0. Then sum 4 -> POINT_SET, and sum 7 -> LOSE, point0 = 0.
- Both buttons rise together after reset -> grant = 01. After that turn, both high again -> grant = 10. A player 1 point of 6 survives a player 0 turn in between.
- 1-cycle press -> cnt_en high exactly 4 cycles. Button held 300 cycles -> cnt_en high exactly 255 cycles, FSM stays in RELEASE with busy = 1 until release, and there is no second roll.
- dice_sum = 13 in EVAL -> err = 1, no res_valid, points unchanged. With WIN_CNT_EN defined: three player 1 wins -> wins1 = 3, and wins saturate at 255.
